// File: rtl/arm_bus_front_end.sv
`default_nettype none
// ============================================================================
// Module  : arm_bus_front_end
// Purpose : ARM static-memory bus front end with strobe synchronisers, an
//           access FSM and read-data return. ARM_BUS_FRONT_END_TIMEOUT_EN adds
//           a strobe timeout.
// Rev     : 1.0
// ============================================================================
module arm_bus_front_end #(
    parameter int SYNC_STAGES    = 2,
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  as,
    input  logic                  ws_n,
    input  logic                  rs_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            be,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr_q,
    output logic [DATA_WIDTH-1:0] wdata_q,
    output logic [3:0]            be_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic                  busy,
    output logic                  proto_err,
    output logic                  timeout_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_CMD   = 3'd1;
    localparam logic [2:0] S_RD_CMD   = 3'd2;
    localparam logic [2:0] S_RD_LATCH = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    logic [SYNC_STAGES-1:0] as_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic                   as_s, ws_s, rs_s;
    logic                   det_wr, det_rd, det_both, strobe_held;
    logic [2:0]             state_q, state_d;
    logic                   data_oe_q, data_oe_d;
    logic                   proto_err_q, proto_err_d;
    logic                   tmo_hit;

    // Synchronisers reset to the idle bus level (as low, strobes high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_sync_q <= '0;
            ws_sync_q <= '1;
            rs_sync_q <= '1;
        end else begin
            as_sync_q <= {as_sync_q[SYNC_STAGES-2:0], as};
            ws_sync_q <= {ws_sync_q[SYNC_STAGES-2:0], ws_n};
            rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], rs_n};
        end
    end

    assign as_s        = as_sync_q[SYNC_STAGES-1];
    assign ws_s        = ~ws_sync_q[SYNC_STAGES-1];
    assign rs_s        = ~rs_sync_q[SYNC_STAGES-1];
    assign det_wr      = as_s & ws_s;
    assign det_rd      = as_s & rs_s & ~ws_s;
    assign det_both    = as_s & ws_s & rs_s;
    assign strobe_held = as_s & (ws_s | rs_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (det_wr) begin
                    state_d = S_WR_CMD;
                end else if (det_rd) begin
                    state_d = S_RD_CMD;
                end
            end
            S_WR_CMD:   state_d = S_HOLD;
            S_RD_CMD:   state_d = S_RD_LATCH;
            S_RD_LATCH: state_d = S_HOLD;
            S_HOLD: begin
                if (!strobe_held) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en = (state_q == S_WR_CMD);
        rd_en = (state_q == S_RD_CMD);
        busy  = (state_q != S_IDLE);
    end

    always_comb begin
        data_oe_d = data_oe_q;
        if (state_q == S_RD_LATCH) begin
            data_oe_d = 1'b1;
        end
        if (state_d == S_IDLE || tmo_hit) begin
            data_oe_d = 1'b0;
        end
        proto_err_d = (proto_err_q & ~err_clr) | ((state_q == S_IDLE) & det_both);
    end

    // Capture registers are only loaded on detection and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            data_out    <= '0;
            data_oe_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && det_wr) begin
                addr_q  <= address;
                wdata_q <= data_in;
                be_q    <= be;
            end else if (state_q == S_IDLE && det_rd) begin
                addr_q  <= address;
            end
            if (state_q == S_RD_LATCH) begin
                data_out <= rdata_in;
            end
            data_oe_q   <= data_oe_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign data_oe   = data_oe_q;
    assign proto_err = proto_err_q;

`ifdef ARM_BUS_FRONT_END_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE && state_d != S_IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_HOLD && tmo_cnt_q != CNT_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        tmo_err_d = (tmo_err_q & ~err_clr) | tmo_hit;
    end

    // Fires on the edge the HOLD counter reaches the limit.
    assign tmo_hit = (state_q == S_HOLD) && (tmo_cnt_d == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    // Constant false: no timeout counter in this build.
    assign tmo_hit     = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arm_bus_front_end.sv
`default_nettype none
// ============================================================================
// Module  : tb_arm_bus_front_end
// Purpose : Directed plus randomized accesses against a timeline model of the
//           ARM bus front end.
// Rev     : 1.0
// ============================================================================
module tb_arm_bus_front_end;

    localparam int S  = 2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int T  = 16;
`ifdef ARM_BUS_FRONT_END_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, as, ws_n, rs_n, err_clr;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, rdata_in;
    logic [3:0]    be;
    logic          wr_en, rd_en, data_oe, busy, proto_err, timeout_err;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, data_out;
    logic [3:0]    be_q;

    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_dout;
    logic [3:0]    exp_be;
    logic          exp_proto, exp_tmo;

    int total = 0;
    int bad   = 0;

    arm_bus_front_end #(
        .SYNC_STAGES(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .as(as), .ws_n(ws_n), .rs_n(rs_n),
        .address(address), .data_in(data_in), .be(be), .rdata_in(rdata_in),
        .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en), .addr_q(addr_q),
        .wdata_q(wdata_q), .be_q(be_q), .data_out(data_out), .data_oe(data_oe),
        .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit e_wr, input bit e_rd, input bit e_busy, input bit e_oe);
        chk("wr_en", {63'd0, wr_en}, {63'd0, e_wr});
        chk("rd_en", {63'd0, rd_en}, {63'd0, e_rd});
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("data_oe", {63'd0, data_oe}, {63'd0, e_oe});
        chk("addr_q", {40'd0, addr_q}, {40'd0, exp_addr});
        chk("wdata_q", {32'd0, wdata_q}, {32'd0, exp_wdata});
        chk("be_q", {60'd0, be_q}, {60'd0, exp_be});
        chk("data_out", {32'd0, data_out}, {32'd0, exp_dout});
        chk("proto_err", {63'd0, proto_err}, {63'd0, exp_proto});
        chk("timeout_err", {63'd0, timeout_err}, {63'd0, exp_tmo});
    endtask

    // kind: 0 write, 1 read, 2 both strobes. Cycle c counts edges after pin
    // assertion; strobes released after cycle `hold`, then S+1+gap idle cycles.
    task automatic do_access(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] b, input logic [DW-1:0] rv,
                             input int hold, input int gap);
        bit is_wr = (kind != 1);
        int h0    = is_wr ? S + 2 : S + 3;
        int hit   = (TMO_EN && (h0 + T <= hold + S + 1)) ? h0 + T : -1;
        address = a;
        data_in = d;
        be      = b;
        as      = 1'b1;
        ws_n    = is_wr ? 1'b0 : 1'b1;
        rs_n    = (kind != 0) ? 1'b0 : 1'b1;
        for (int c = 1; c <= hold + S + 1 + gap; c++) begin
            step();
            if (c == S + 1) begin
                exp_addr = a;
                if (is_wr) begin
                    exp_wdata = d;
                    exp_be    = b;
                end
                if (kind == 2) exp_proto = 1'b1;
            end
            if (!is_wr && c == S + 3) exp_dout = rv;
            if (c == hit) exp_tmo = 1'b1;
            check_all(is_wr && c == S + 1, !is_wr && c == S + 1,
                      c >= S + 1 && c <= hold + S,
                      !is_wr && c >= S + 3 && c <= hold + S && !(hit > 0 && c >= hit));
            rdata_in = (c == S + 2) ? rv : DW'($urandom);
            if (c == hold) begin
                ws_n = 1'b1;
                rs_n = 1'b1;
                as   = 1'($urandom_range(0, 1));
            end
            if (c > hold) begin
                address = AW'($urandom);
                data_in = DW'($urandom);
                be      = 4'($urandom);
            end
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr   = 1'b0;
        exp_proto = 1'b0;
        exp_tmo   = 1'b0;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        rst_n = 1'b0; as = 1'b0; ws_n = 1'b1; rs_n = 1'b1; err_clr = 1'b0;
        address = '0; data_in = '0; be = '0; rdata_in = '0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0; exp_dout = '0;
        exp_proto = 1'b0; exp_tmo = 1'b0;

        step();
        step();
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_all(1'b0, 1'b0, 1'b0, 1'b0);

        // Directed write, read, back-to-back with minimum strobe-high gap
        do_access(0, 24'h000004, 32'hDEADBEEF, 4'hF, 32'h0, 10, 1);
        do_access(1, 24'h000008, 32'h0BADF00D, 4'h3, 32'h12345678, 10, 1);
        do_access(0, 24'h0000A0, 32'hCAFEF00D, 4'h5, 32'h0, 5, 1);
        do_access(1, 24'h0000A4, 32'h0, 4'h0, 32'hA5A5_5A5A, 5, 1);

        // Both strobes together: write wins, sticky protocol error
        do_access(2, 24'h000010, 32'h11223344, 4'hC, 32'h0, 6, 2);
        clear_errors();

        for (int i = 0; i < 14; i++) begin
            do_access($urandom_range(0, 2), AW'($urandom), DW'($urandom), 4'($urandom),
                      DW'($urandom), $urandom_range(S + 2, 12), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) clear_errors();
        end

        // Long-held strobe: no re-issue; timeout when that feature is built
        do_access(1, 24'h00F00D, 32'h0, 4'h0, DW'($urandom), 40, 2);
        do_access(0, 24'h00BEEF, DW'($urandom), 4'hA, 32'h0, 30, 2);
        clear_errors();

        // Reset while in RD_LATCH with the read strobe still held
        ra      = AW'($urandom);
        address = ra;
        as      = 1'b1;
        ws_n    = 1'b1;
        rs_n    = 1'b0;
        for (int c = 1; c <= S + 2; c++) step();
        chk("busy_pre_reset", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        exp_addr = '0; exp_wdata = '0; exp_be = '0; exp_dout = '0;
        exp_proto = 1'b0; exp_tmo = 1'b0;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        do_access(1, ra, 32'h0, 4'h0, DW'($urandom), 8, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
